// File: rtl/ctrl_pipe_stager.sv
// Carries decoded control bits and register specifiers through the EX/MEM/WB pipeline registers,
// with load-use stall detection, taken-branch/jump flush and EX-stage operand forwarding selects.
module ctrl_pipe_stager #(
    parameter int unsigned REG_W        = 5,
    parameter bit          NOP_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_reg_dest,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_op1,
    input  logic             id_alu_op2,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_jump,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rt,
    input  logic             mem_zero,
    output logic             ex_alu_op1,
    output logic             ex_alu_op2,
    output logic             ex_alu_src,
    output logic             ex_reg_dest,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] ex_dest,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_branch,
    output logic [REG_W-1:0] mem_dest,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [REG_W-1:0] wb_dest,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pc_src,
    output logic             if_flush
);

    localparam int unsigned FWD_W   = 2;
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic             alu_op1;
        logic             alu_op2;
        logic             alu_src;
        logic             reg_dest;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
    } ex_stage_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dest;
    } mem_stage_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dest;
    } wb_stage_t;

    ex_stage_t  ex_q,  ex_d,  id_cap;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;
    logic       load_hit;
    logic       stall;

    function automatic logic [FWD_W-1:0] fwd_sel(
        input mem_stage_t       m,
        input wb_stage_t        w,
        input logic [REG_W-1:0] src
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (m.reg_write && (m.dest != '0) && (m.dest == src)) begin
            sel = FWD_MEM;
        end else if (w.reg_write && (w.dest != '0) && (w.dest == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Hazard and redirect decisions; a taken branch overrides a coincident stall.
    assign pc_src     = mem_q.branch & mem_zero;
    assign load_hit   = ex_q.mem_read && (ex_q.dest != '0) &&
                        ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)));
    assign stall      = load_hit & ~pc_src;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign if_flush   = pc_src | (id_jump & ~load_hit);

    assign forward_a  = fwd_sel(mem_q, wb_q, ex_q.rs);
    assign forward_b  = fwd_sel(mem_q, wb_q, ex_q.rt);

    // ID->EX capture, replaced by a bubble on stall or flush.
    always_comb begin
        id_cap            = '0;
        id_cap.alu_op1    = id_alu_op1;
        id_cap.alu_op2    = id_alu_op2;
        id_cap.alu_src    = id_alu_src;
        id_cap.reg_dest   = id_reg_dest;
        id_cap.mem_read   = id_mem_read;
        id_cap.mem_write  = id_mem_write;
        id_cap.branch     = id_branch;
        id_cap.reg_write  = id_reg_write;
        id_cap.mem_to_reg = id_mem_to_reg;
        id_cap.rs         = id_rs;
        id_cap.rt         = id_rt;
        id_cap.dest       = id_reg_dest ? id_rd : id_rt;

        ex_d = id_cap;
        if (pc_src) begin
            ex_d = '0;
            if (!NOP_ON_FLUSH) begin
                ex_d.rs   = id_cap.rs;
                ex_d.rt   = id_cap.rt;
                ex_d.dest = id_cap.dest;
            end
        end else if (stall) begin
            ex_d = '0;
        end
    end

    // EX->MEM transfer; a taken branch kills the instruction leaving EX.
    always_comb begin
        mem_d            = '0;
        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.branch     = ex_q.branch;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.dest       = ex_q.dest;
        if (pc_src) begin
            mem_d = '0;
            if (!NOP_ON_FLUSH) begin
                mem_d.dest = ex_q.dest;
            end
        end
    end

    always_comb begin
        wb_d            = '0;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.mem_to_reg = mem_q.mem_to_reg;
        wb_d.dest       = mem_q.dest;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_alu_op1    = ex_q.alu_op1;
    assign ex_alu_op2    = ex_q.alu_op2;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_dest   = ex_q.reg_dest;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_dest       = ex_q.dest;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_mem_write = mem_q.mem_write;
    assign mem_branch    = mem_q.branch;
    assign mem_dest      = mem_q.dest;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_dest       = wb_q.dest;

endmodule
